arith_pipe_alu: RTL and testbench
=================================

Name: arith_pipe_alu

Overview:
Parametrised, registered successor to the team's combinational n-bit adder/overflow block. It adds a subtract mode, a running accumulator, optional signed saturation, a sticky overflow flag and a valid/ready handshake with a one-stage output register. It sits between a producer of operand pairs and a consumer of results in the arithmetic datapath.

Parameters:
N, 4, operand/result width in bits (N >= 2)
SAT, 0, 1 = signed-saturate out_s/out_acc on overflow; 0 = wrap modulo 2^N
CNT_W, 8, width of accepted-operation counter

Ports:
in_clk  input  1  clock, all logic on rising edge
in_rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream operand valid
out_ready  output  1  block can accept operands this cycle
in_op  input  2  00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB
in_x  input  N  operand x
in_y  input  N  operand y (ignored for ACC ops)
in_clr_acc  input  1  clear accumulator
in_clr_sticky  input  1  clear sticky overflow
out_valid  output  1  result valid
in_ready  input  1  downstream accepts result
out_s  output  N  result
out_c  output  1  raw carry-out (SUB/ACC_SUB: 1 = no borrow)
out_overflow  output  1  signed overflow of this result
out_sticky_ovf  output  1  OR of overflow since last clear
out_acc  output  N  current accumulator
out_count  output  CNT_W  accepted-operation count

Behaviour:
- Reset (in_rst=1 at edge): out_valid=0, out_s=0, out_c=0, out_overflow=0, out_sticky_ovf=0, out_acc=0, out_count=0. Reset mid-transaction drops any held result; no partial accumulator update survives.
- out_ready = ~out_valid | in_ready (combinational; never depends on in_valid).
- Accept = in_valid & out_ready at rising edge. Latency 1: result registered on accept, out_valid=1 next cycle.
- Hold: while out_valid & ~in_ready, out_s/out_c/out_overflow stable, no accept.
- Result leaves when out_valid & in_ready; if no accept that cycle, out_valid->0 next cycle; with accept, back-to-back full throughput.
- Arithmetic on N+1 bits: ADD a=x, b=y; SUB a=x, b=~y, cin=1; ACC_ADD a=acc, b=x; ACC_SUB a=acc, b=~x, cin=1. out_c = bit N of sum.
- Overflow = (a[N-1]==b[N-1]) & (sum[N-1]!=a[N-1]) using post-inversion b.
- SAT=1 and overflow: result = 0 1..1 if a[N-1]=0 else 1 0..0; out_c unaffected. SAT=0: result = sum[N-1:0].
- ACC ops: out_acc <= result on accept; out_s = same result. ADD/SUB leave acc unchanged.
- in_clr_acc (independent of handshake): acc <= 0. If same cycle as ACC op accept, the op uses acc=0 as operand and its result is stored (clear first, then op).
- Sticky: set on accept with overflow; in_clr_sticky clears; set wins when simultaneous.
- out_count increments by 1 per accept, wraps 2^CNT_W-1 -> 0.
- in_op/in_x/in_y sampled only on accept; don't-care otherwise.

Test Plan:
- N=4,SAT=0, in_ready=1: ADD x=5,y=6 -> next cycle out_s=11, out_c=0, out_overflow=1, out_sticky_ovf=1; then ADD 1,3 -> out_s=4, ovf=0, sticky still 1.
- SAT=1: ADD 5,6 -> out_s=7, out_overflow=1; SUB x=8(-8),y=1 -> out_s=8 (-8 saturated), out_c=1, ovf=1.
- SUB 3,5 -> out_s=14, out_c=0, ovf=0; SUB 5,3 -> out_s=2, out_c=1.
- in_clr_acc, then ACC_ADD 7, ACC_ADD 1 back-to-back -> out_acc 7 then 8, second ovf=1; ACC_ADD 2 with in_clr_acc same cycle -> out_acc=2.
- Backpressure: in_ready=0 after one accept -> out_ready=0, out_s held 3 cycles, in_valid ignored; in_ready=1 -> queued op accepted, out_count advances by exactly 2.
- Reset asserted while out_valid=1 and acc=5 -> next cycle all outputs 0; in_clr_sticky with overflow accept same cycle -> sticky stays 1; CNT_W=2 after 4 accepts -> out_count=0.

Source files
------------

// File: rtl/arith_pipe_alu.sv
// arith_pipe_alu: registered N-bit add/subtract ALU with running accumulator,
// optional signed saturation, sticky overflow and a one-stage valid/ready
// output register.
module arith_pipe_alu #(
    parameter int N     = 4,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    input  logic             in_clr_acc,
    input  logic             in_clr_sticky,
    output logic             out_valid,
    input  logic             in_ready,
    output logic [N-1:0]     out_s,
    output logic             out_c,
    output logic             out_overflow,
    output logic             out_sticky_ovf,
    output logic [N-1:0]     out_acc,
    output logic [CNT_W-1:0] out_count
);

    logic         accept;
    logic [N-1:0] acc_q;
    logic [N-1:0] acc_eff;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N:0]   sum;
    logic         ovf;
    logic [N-1:0] sat_val;
    logic [N-1:0] result;

    // The output stage frees up either when empty or when its result leaves.
    assign out_ready = ~out_valid | in_ready;
    assign accept    = in_valid & out_ready;
    assign out_acc   = acc_q;

    // A clear in the same cycle as an ACC op makes the op see a zero accumulator.
    assign acc_eff = in_clr_acc ? '0 : acc_q;

    // Operand selection, N+1-bit add, signed overflow and optional saturation.
    always_comb begin
        a   = in_x;
        b   = in_y;
        cin = 1'b0;
        case (in_op)
            2'b01: begin
                b   = ~in_y;
                cin = 1'b1;
            end
            2'b10: begin
                a = acc_eff;
                b = in_x;
            end
            2'b11: begin
                a   = acc_eff;
                b   = ~in_x;
                cin = 1'b1;
            end
            default: ;
        endcase
        sum     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        ovf     = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        sat_val = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        result  = ((SAT != 0) && ovf) ? sat_val : sum[N-1:0];
    end

    // Output register: load on accept, drop valid once the result has left.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_valid    <= 1'b0;
            out_s        <= '0;
            out_c        <= 1'b0;
            out_overflow <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_s        <= result;
            out_c        <= sum[N];
            out_overflow <= ovf;
        end else if (in_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Accumulator: ACC ops store their result, otherwise honour the clear.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            acc_q <= '0;
        end else if (accept && in_op[1]) begin
            acc_q <= result;
        end else begin
            acc_q <= acc_eff;
        end
    end

    // Sticky overflow: a new overflow wins over a simultaneous clear.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_sticky_ovf <= 1'b0;
        end else if (accept && ovf) begin
            out_sticky_ovf <= 1'b1;
        end else if (in_clr_sticky) begin
            out_sticky_ovf <= 1'b0;
        end
    end

    // Accepted-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_count <= '0;
        end else if (accept) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_arith_pipe_alu.sv
// Scoreboard bench for arith_pipe_alu: two instances (wrap/CNT_W=8 and
// saturate/CNT_W=2) share one stimulus stream; a signed-integer reference
// model pushes expected results and a negedge monitor compares them.
module tb_arith_pipe_alu;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, valid, clr_acc, clr_sticky, rdy;
    logic [1:0] op;
    logic [3:0] x, y;

    logic       ready0, valid0, c0, ovf0, st0;
    logic [3:0] s0, acc0;
    logic [7:0] cnt0;
    logic       ready1, valid1, c1, ovf1, st1;
    logic [3:0] s1, acc1;
    logic [1:0] cnt1;

    arith_pipe_alu #(.N(N), .SAT(0), .CNT_W(8)) dut0 (
        .in_clk(clk), .in_rst(rst), .in_valid(valid), .out_ready(ready0),
        .in_op(op), .in_x(x), .in_y(y), .in_clr_acc(clr_acc),
        .in_clr_sticky(clr_sticky), .out_valid(valid0), .in_ready(rdy),
        .out_s(s0), .out_c(c0), .out_overflow(ovf0), .out_sticky_ovf(st0),
        .out_acc(acc0), .out_count(cnt0)
    );

    arith_pipe_alu #(.N(N), .SAT(1), .CNT_W(2)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_valid(valid), .out_ready(ready1),
        .in_op(op), .in_x(x), .in_y(y), .in_clr_acc(clr_acc),
        .in_clr_sticky(clr_sticky), .out_valid(valid1), .in_ready(rdy),
        .out_s(s1), .out_c(c1), .out_overflow(ovf1), .out_sticky_ovf(st1),
        .out_acc(acc1), .out_count(cnt1)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int s0; int c0; int o0;
        int s1; int c1; int o1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state (per configuration where it can differ)
    bit   m_valid = 1'b0;
    bit   just_reset = 1'b0;
    int   m_acc0 = 0, m_acc1 = 0;
    int   m_st0 = 0, m_st1 = 0;
    int   m_cnt0 = 0, m_cnt1 = 0;

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Plain-integer model: true signed value, range check, carry as
    // unsigned-overflow (ADD) or no-borrow (SUB) condition.
    function automatic void alu_model(input int opc, input int xv, input int yv,
                                      input int accv, input bit sat,
                                      output int s, output int c, output int o);
        int t;
        case (opc)
            0: begin t = to_signed4(xv) + to_signed4(yv);   c = (xv + yv >= 16) ? 1 : 0; end
            1: begin t = to_signed4(xv) - to_signed4(yv);   c = (xv >= yv) ? 1 : 0; end
            2: begin t = to_signed4(accv) + to_signed4(xv); c = (accv + xv >= 16) ? 1 : 0; end
            default: begin t = to_signed4(accv) - to_signed4(xv); c = (accv >= xv) ? 1 : 0; end
        endcase
        o = (t > 7 || t < -8) ? 1 : 0;
        if (sat && o == 1) s = (t > 7) ? 7 : 8;
        else               s = t & 15;
    endfunction

    task automatic model_step();
        bit   rdy_m, acc_t;
        int   a0, a1;
        exp_t e;
        if (rst) begin
            m_valid = 1'b0; q.delete();
            m_acc0 = 0; m_acc1 = 0; m_st0 = 0; m_st1 = 0;
            m_cnt0 = 0; m_cnt1 = 0; just_reset = 1'b1;
            return;
        end
        rdy_m = !m_valid || rdy;
        acc_t = valid && rdy_m;
        a0 = clr_acc ? 0 : m_acc0;
        a1 = clr_acc ? 0 : m_acc1;
        if (acc_t) begin
            alu_model(int'(op), int'(x), int'(y), a0, 1'b0, e.s0, e.c0, e.o0);
            alu_model(int'(op), int'(x), int'(y), a1, 1'b1, e.s1, e.c1, e.o1);
            q.push_back(e);
            m_acc0 = (op >= 2) ? e.s0 : a0;
            m_acc1 = (op >= 2) ? e.s1 : a1;
            m_st0  = (e.o0 == 1) ? 1 : (clr_sticky ? 0 : m_st0);
            m_st1  = (e.o1 == 1) ? 1 : (clr_sticky ? 0 : m_st1);
            m_cnt0 = (m_cnt0 + 1) % 256;
            m_cnt1 = (m_cnt1 + 1) % 4;
            m_valid = 1'b1;
        end else begin
            m_acc0 = a0; m_acc1 = a1;
            if (clr_sticky) begin m_st0 = 0; m_st1 = 0; end
            if (rdy) m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compares outputs each negedge; pops when a result leaves.
    always @(negedge clk) begin
        exp_t e;
        chk("ready0", int'(ready0), int'(!m_valid || rdy));
        chk("ready1", int'(ready1), int'(!m_valid || rdy));
        chk("valid0", int'(valid0), int'(m_valid));
        chk("valid1", int'(valid1), int'(m_valid));
        chk("acc0", int'(acc0), m_acc0);
        chk("acc1", int'(acc1), m_acc1);
        chk("sticky0", int'(st0), m_st0);
        chk("sticky1", int'(st1), m_st1);
        chk("count0", int'(cnt0), m_cnt0);
        chk("count1", int'(cnt1), m_cnt1);
        if (just_reset) begin
            just_reset = 1'b0;
            chk("rst_s0", int'(s0), 0);  chk("rst_c0", int'(c0), 0);  chk("rst_o0", int'(ovf0), 0);
            chk("rst_s1", int'(s1), 0);  chk("rst_c1", int'(c1), 0);  chk("rst_o1", int'(ovf1), 0);
        end
        if (valid0) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = q[0];
                chk("s0", int'(s0), e.s0);  chk("c0", int'(c0), e.c0);  chk("ovf0", int'(ovf0), e.o0);
                chk("s1", int'(s1), e.s1);  chk("c1", int'(c1), e.c1);  chk("ovf1", int'(ovf1), e.o1);
                if (rdy) void'(q.pop_front());
            end
        end
    end

    task automatic cycle(input bit v, input int o, input int xv, input int yv,
                         input bit ca, input bit cs, input bit r, input bit rs);
        valid = v; op = 2'(o); x = 4'(xv); y = 4'(yv);
        clr_acc = ca; clr_sticky = cs; rdy = r; rst = rs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        // reset
        cycle(0, 0, 0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // ADD with overflow, then clean ADD (sticky must persist)
        cycle(1, 0, 5, 6, 0, 0, 1, 0);
        cycle(1, 0, 1, 3, 0, 0, 1, 0);
        // SUB -8 - 1 saturates / wraps; SUB borrow and no-borrow
        cycle(1, 1, 8, 1, 0, 0, 1, 0);
        cycle(1, 1, 3, 5, 0, 0, 1, 0);
        cycle(1, 1, 5, 3, 0, 0, 1, 0);
        // accumulator: clear, +7, +1 (overflow), +2 with same-cycle clear
        cycle(0, 0, 0, 0, 1, 0, 1, 0);
        cycle(1, 2, 7, 0, 0, 0, 1, 0);
        cycle(1, 2, 1, 0, 0, 0, 1, 0);
        cycle(1, 2, 2, 0, 1, 0, 1, 0);
        cycle(1, 3, 9, 0, 0, 0, 1, 0);
        // backpressure: hold three cycles with a pending operand
        cycle(1, 0, 2, 3, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 4, 4, 0, 0, 0, 0);
        cycle(1, 0, 4, 4, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // overflow accept with simultaneous sticky clear: set wins
        cycle(0, 0, 0, 0, 0, 1, 1, 0);
        cycle(1, 0, 5, 6, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // reset while a result is held and acc is nonzero
        cycle(1, 2, 5, 0, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2));
        end
        // drain
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
